// File: rtl/fb_write_arbiter.sv
// Purpose: small synchronous FIFO holding pending frame-buffer writes.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: a push into a full FIFO is ignored unless a pop happens in the same cycle.
module fb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         full
);
  // DEPTH must be a power of two so that the pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt, cnt_nxt;
  logic          do_push, do_pop;

  assign out_vld = (cnt != '0);
  assign out_dat = mem[rd_ptr];
  assign do_pop  = out_rdy && out_vld;
  assign do_push = in_vld && (!full || do_pop);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_nxt = cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Pointer, count and full-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == (PW+1)'(DEPTH));
    end
  end

  // Storage array, no reset needed since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end
endmodule

// Purpose: parses UART pixel commands, runs full-screen clear, arbitrates the single RAM port.
// Latency: command write hits RAM at the earliest the cycle after its colour byte; VGA read data valid one cycle after request.
// Backpressure: VGA reads always win; clear then FIFO use idle cycles; a command hitting a full FIFO is dropped with cmd_error.
module fb_write_arbiter #(
  parameter int H_PIX      = 160,
  parameter int V_PIX      = 120,
  parameter int ADDR_W     = 15,
  parameter int COL_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK_50MHz,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [COL_W-1:0]  vga_rd_data,
  output logic              vga_rd_valid,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [COL_W-1:0]  fb_wdata,
  input  logic [COL_W-1:0]  fb_rdata,
  output logic              cmd_error,
  output logic              busy,
  output logic              fifo_full
);
  localparam logic [7:0]        B_RESYNC = 8'hFF;
  localparam logic [7:0]        B_CLEAR  = 8'hFE;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_PIX * V_PIX - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
  } wr_cmd_t;

  typedef enum logic [1:0] {S_X, S_Y, S_C} state_t;

  state_t            state, state_nxt;
  logic [7:0]        x_lat, y_lat, x_nxt, y_nxt;
  logic              push, parse_err, clear_start, drop;
  wr_cmd_t           push_dat, head;
  logic              head_vld, pop, clr_grant;
  logic [ADDR_W-1:0] clr_cnt;

  // Parser next state: 0xFF resyncs from anywhere, 0xFE in S_X requests a clear.
  always_comb begin
    state_nxt   = state;
    x_nxt       = x_lat;
    y_nxt       = y_lat;
    push        = 1'b0;
    parse_err   = 1'b0;
    clear_start = 1'b0;
    if (rx_valid) begin
      if (rx_data == B_RESYNC) begin
        state_nxt = S_X;
      end else begin
        case (state)
          S_X: begin
            if (rx_data == B_CLEAR) begin
              if (busy) parse_err   = 1'b1;
              else      clear_start = 1'b1;
            end else if (rx_data < 8'(H_PIX)) begin
              x_nxt     = rx_data;
              state_nxt = S_Y;
            end else begin
              parse_err = 1'b1;
            end
          end
          S_Y: begin
            if (rx_data < 8'(V_PIX)) begin
              y_nxt     = rx_data;
              state_nxt = S_C;
            end else begin
              parse_err = 1'b1;
              state_nxt = S_X;
            end
          end
          S_C: begin
            push      = 1'b1;
            state_nxt = S_X;
          end
          default: state_nxt = S_X;
        endcase
      end
    end
  end

  // Linear pixel address and colour for the command being completed.
  always_comb begin
    push_dat.addr = ADDR_W'(y_lat) * ADDR_W'(H_PIX) + ADDR_W'(x_lat);
    push_dat.col  = rx_data[COL_W-1:0];
  end

  // Single RAM port mux: VGA read, then clear, then pending FIFO write.
  always_comb begin
    fb_addr   = '0;
    fb_we     = 1'b0;
    fb_wdata  = '0;
    pop       = 1'b0;
    clr_grant = 1'b0;
    if (vga_rd_req) begin
      fb_addr = vga_rd_addr;
    end else if (busy) begin
      fb_addr   = clr_cnt;
      fb_we     = 1'b1;
      clr_grant = 1'b1;
    end else if (head_vld) begin
      fb_addr  = head.addr;
      fb_wdata = head.col;
      fb_we    = 1'b1;
      pop      = 1'b1;
    end
  end

  // A completed command is lost only if the FIFO is full and not draining this cycle.
  assign drop = push && fifo_full && !pop;

  fb_fifo #(
    .W     ($bits(wr_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_50MHz),
    .rst_n   (reset),
    .in_vld  (push),
    .in_dat  (push_dat),
    .out_rdy (pop),
    .out_vld (head_vld),
    .out_dat (head),
    .full    (fifo_full)
  );

  // Parser state and coordinate latches.
  always_ff @(posedge CLK_50MHz or negedge reset) begin
    if (!reset) begin
      state <= S_X;
      x_lat <= '0;
      y_lat <= '0;
    end else begin
      state <= state_nxt;
      x_lat <= x_nxt;
      y_lat <= y_nxt;
    end
  end

  // Clear sequencer: counter advances only on cycles the port is granted to it.
  always_ff @(posedge CLK_50MHz or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      clr_cnt <= '0;
    end else if (clear_start) begin
      busy <= 1'b1;
    end else if (clr_grant) begin
      if (clr_cnt == CLR_LAST) begin
        busy    <= 1'b0;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
    end
  end

  // Error pulse and VGA read-valid pipeline.
  always_ff @(posedge CLK_50MHz or negedge reset) begin
    if (!reset) begin
      cmd_error    <= 1'b0;
      vga_rd_valid <= 1'b0;
    end else begin
      cmd_error    <= parse_err | drop;
      vga_rd_valid <= vga_rd_req;
    end
  end

  // RAM read data is already one cycle behind its address.
  assign vga_rd_data = fb_rdata;
endmodule
